// File: rtl/prog_load_pkg.sv
// Shared types for the UART program loader: sequencer states, abort codes,
// and the word-packing width.
package prog_load_pkg;

    // State order follows the frame layout on the wire: length, data, checksum.
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_LEN     = 2'b01;
    localparam logic [1:0] ERR_CSUM    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam int BYTES_PER_WORD = 4;

    function automatic logic in_frame(input state_e s);
        return s inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK};
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Collects bytes into little-endian 32-bit words; the first byte of a word
// lands in bits 7:0. word/word_valid are presented with the 4th byte.
module byte_packer
    import prog_load_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  byte_cnt;
    logic [23:0] shift_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byte_cnt  <= '0;
            shift_reg <= '0;
        end else if (clear) begin
            byte_cnt  <= '0;
        end else if (in_valid) begin
            byte_cnt  <= byte_cnt + 2'd1;
            shift_reg <= {in_byte, shift_reg[23:8]};
        end
    end

    assign word_valid = in_valid && (byte_cnt == 2'(BYTES_PER_WORD - 1));
    assign word       = {in_byte, shift_reg};

endmodule

// File: rtl/prog_load_ctrl.sv
// UART programming sequencer: parses a length-prefixed frame, writes packed
// words to the instruction ROM and verifies the trailing XOR checksum.
module prog_load_ctrl
    import prog_load_pkg::*;
#(
    parameter int ADDR_W  = 14,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              upg_wen_o,
    output logic [ADDR_W-1:0] upg_adr_o,
    output logic [31:0]       upg_dat_o,
    output logic              upg_rst_o,
    output logic              upg_done_o,
    output logic              busy,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_e            state, state_next;
    logic [1:0]        abort_code;
    logic [7:0]        len_lo;
    logic [15:0]       words_left;
    logic [ADDR_W-1:0] addr_cnt;
    logic [7:0]        csum;
    logic [TW-1:0]     idle_cnt;
    logic              word_valid;
    logic [31:0]       word;
    logic [15:0]       frame_len;
    logic              len_over;
    logic              timeout_hit;
    logic              data_byte;

    assign frame_len   = {rx_data, len_lo};
    assign len_over    = 32'(frame_len) > (32'd1 << ADDR_W);
    // A byte arriving on the expiry cycle still counts.
    assign timeout_hit = !rx_valid && (idle_cnt == TW'(TIMEOUT - 1));
    assign data_byte   = rx_valid && (state == S_DATA);

    byte_packer u_packer (
        .clock      (clock),
        .reset      (reset),
        .clear      (state == S_IDLE),
        .in_valid   (data_byte),
        .in_byte    (rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        abort_code = ERR_NONE;
        case (state)
            S_IDLE:   if (start) state_next = S_LEN_LO;
            S_LEN_LO: begin
                if (rx_valid)         state_next = S_LEN_HI;
                else if (timeout_hit) begin state_next = S_ERROR; abort_code = ERR_TIMEOUT; end
            end
            S_LEN_HI: begin
                if (rx_valid) begin
                    if (len_over)              begin state_next = S_ERROR; abort_code = ERR_LEN; end
                    else if (frame_len == '0)  state_next = S_CHECK;
                    else                       state_next = S_DATA;
                end else if (timeout_hit) begin state_next = S_ERROR; abort_code = ERR_TIMEOUT; end
            end
            S_DATA: begin
                if (rx_valid) begin
                    if (word_valid && words_left == 16'd1) state_next = S_CHECK;
                end else if (timeout_hit) begin state_next = S_ERROR; abort_code = ERR_TIMEOUT; end
            end
            S_CHECK: begin
                if (rx_valid) begin
                    if (rx_data == csum) state_next = S_DONE;
                    else begin state_next = S_ERROR; abort_code = ERR_CSUM; end
                end else if (timeout_hit) begin state_next = S_ERROR; abort_code = ERR_TIMEOUT; end
            end
            S_DONE:   state_next = S_IDLE;
            S_ERROR:  state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = in_frame(state);
        upg_rst_o = !in_frame(state);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            upg_wen_o  <= 1'b0;
            upg_adr_o  <= '0;
            upg_dat_o  <= '0;
            addr_cnt   <= '0;
            words_left <= '0;
            len_lo     <= '0;
            csum       <= '0;
            idle_cnt   <= '0;
        end else begin
            upg_wen_o <= data_byte && word_valid;
            if (data_byte && word_valid) begin
                upg_adr_o  <= addr_cnt;
                upg_dat_o  <= word;
                addr_cnt   <= addr_cnt + 1'b1;
                words_left <= words_left - 16'd1;
            end
            if (data_byte) csum <= csum ^ rx_data;
            if (state == S_LEN_LO && rx_valid) len_lo <= rx_data;
            if (state == S_LEN_HI && rx_valid) words_left <= frame_len;
            if (state == S_IDLE && start) begin
                addr_cnt <= '0;
                csum     <= '0;
            end
            if (!in_frame(state) || rx_valid) idle_cnt <= '0;
            else                              idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // Status flags survive until the next accepted start so software can read them.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            upg_done_o <= 1'b0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
        end else if (state == S_IDLE && start) begin
            upg_done_o <= 1'b0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
        end else if (state != S_ERROR && state_next == S_ERROR) begin
            err        <= 1'b1;
            err_code   <= abort_code;
        end else if (state_next == S_DONE) begin
            upg_done_o <= 1'b1;
        end
    end

endmodule
